note_remap: RTL

Play-side consumer of the learned key table. Takes the seven 7-bit mapping entries produced by the adjust block and translates debounced raw key presses into remapped notes for the buzzer path. In review mode it steps through the table entries autonomously so the user can hear or see the learned mapping. It sits between the key/switch inputs and the note player, in parallel with the adjust block.

---
 rtl/note_remap_pkg.sv | 39 +++
 rtl/note_remap_tick_gen.sv | 32 +++
 rtl/note_remap.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_remap_pkg.sv
// Shared constants for the note remapping path: global mode codes, the
// silence note code, entry indices of the learned key table, and a helper
// that turns a one-hot key pattern into a table entry number.
package note_remap_pkg;

    // Global mode codes; any other value parks the play side.
    localparam logic [2:0] mode_play   = 3'd1;
    localparam logic [2:0] mode_review = 3'd2;

    // Note code meaning "no sound".
    localparam logic [6:0] note_silence = 7'h00;

    // Table entry indices; 0 means no entry selected.
    localparam logic [2:0] n_none = 3'd0;
    localparam logic [2:0] n_do   = 3'd1;
    localparam logic [2:0] n_re   = 3'd2;
    localparam logic [2:0] n_mi   = 3'd3;
    localparam logic [2:0] n_fa   = 3'd4;
    localparam logic [2:0] n_so   = 3'd5;
    localparam logic [2:0] n_la   = 3'd6;
    localparam logic [2:0] n_q1   = 3'd7;

    // Entry number (bit index + 1) of a single-bit key pattern, or n_none
    // when the pattern is empty or has more than one bit set.
    function automatic logic [2:0] onehot_entry(input logic [6:0] k);
        logic [2:0] idx;
        int         ones;
        idx  = n_none;
        ones = 0;
        for (int i = 0; i < 7; i++) begin
            if (k[i]) begin
                ones = ones + 1;
                idx  = 3'(i + 1);
            end
        end
        return (ones == 1) ? idx : n_none;
    endfunction

endpackage

// File: rtl/note_remap_tick_gen.sv
// Sample tick generator: one-cycle enable every CLK_HZ/TICK_HZ clocks.
// Kept free of any note-specific logic so other sampling blocks can reuse it.
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);

    localparam int          DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int          DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam logic [31:0] LAST    = 32'(DIV - 1);

    logic [31:0] cnt;

    // Free-running divider; the tick is registered so it is glitch-free.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 32'd1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/note_remap.sv
// Play-side consumer of the learned key table. Debounces one-hot key
// presses into remapped notes, or in review mode walks the table entries
// on a fixed tick cadence so the learned mapping can be heard.
module note_remap
    import note_remap_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 100,
    parameter int DEB_TICKS    = 2,
    parameter int REVIEW_TICKS = 50
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic [6:0] key,
    input  logic [6:0] map1,
    input  logic [6:0] map2,
    input  logic [6:0] map3,
    input  logic [6:0] map4,
    input  logic [6:0] map5,
    input  logic [6:0] map6,
    input  logic [6:0] map7,
    output logic [6:0] note_out,
    output logic       note_valid,
    output logic [2:0] key_idx,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE,
        S_REVIEW
    } state_t;

    localparam logic [15:0] DEB_LIM = 16'((DEB_TICKS < 1) ? 1 : DEB_TICKS);
    localparam logic [15:0] REV_LIM = 16'((REVIEW_TICKS < 1) ? 1 : REVIEW_TICKS);

    logic        tick;
    logic [2:0]  mode_s1, mode_s2, mode_prev;
    logic [6:0]  key_s1, key_s2;
    logic [6:0]  cand;
    logic [15:0] deb_cnt;
    logic [15:0] rev_cnt;
    state_t      state;

    logic [6:0]  map_tab [0:7];
    logic [2:0]  key_entry;
    logic [2:0]  rev_next;
    logic        mode_changed;
    logic        play_tick;
    logic        go_hold;
    logic        go_release;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (tick)
    );

    // Two-flop synchronizers for the asynchronous switch inputs, plus the
    // previous synchronized mode used to spot mode transitions.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mode_s1   <= '0;
            mode_s2   <= '0;
            mode_prev <= '0;
            key_s1    <= '0;
            key_s2    <= '0;
        end else begin
            mode_s1   <= mode;
            mode_s2   <= mode_s1;
            mode_prev <= mode_s2;
            key_s1    <= key;
            key_s2    <= key_s1;
        end
    end

    // Indexable view of the learned table; slot 0 reads as silence so a
    // chord (key_idx 0) naturally tracks to a silent output.
    always_comb begin
        map_tab[n_none] = note_silence;
        map_tab[n_do]   = map1;
        map_tab[n_re]   = map2;
        map_tab[n_mi]   = map3;
        map_tab[n_fa]   = map4;
        map_tab[n_so]   = map5;
        map_tab[n_la]   = map6;
        map_tab[n_q1]   = map7;
    end

    // Hold-entry and release-complete decisions, kept out of the state
    // register block so every state that can finish a debounce shares them.
    always_comb begin
        key_entry    = onehot_entry(key_s2);
        rev_next     = (key_idx == n_q1) ? n_do : key_idx + 3'd1;
        mode_changed = (mode_s2 != mode_prev);
        play_tick    = tick && (mode_s2 == mode_play) && !mode_changed;
        go_hold      = 1'b0;
        go_release   = 1'b0;
        if (play_tick && (key_s2 != 7'd0)) begin
            case (state)
                S_IDLE, S_RELEASE: go_hold = (DEB_LIM <= 16'd1);
                S_DEBOUNCE: begin
                    if (key_s2 == cand)
                        go_hold = ((deb_cnt + 16'd1) >= DEB_LIM);
                    else
                        go_hold = (DEB_LIM <= 16'd1);
                end
                default: go_hold = 1'b0;
            endcase
        end
        if (play_tick && (key_s2 == 7'd0)) begin
            case (state)
                S_HOLD:    go_release = (DEB_LIM <= 16'd1);
                S_RELEASE: go_release = ((deb_cnt + 16'd1) >= DEB_LIM);
                default:   go_release = 1'b0;
            endcase
        end
    end

    // Main FSM with registered outputs: a mode change clears everything
    // silently, review walks the table, play debounces presses and releases.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cand       <= '0;
            deb_cnt    <= '0;
            rev_cnt    <= '0;
            note_out   <= note_silence;
            note_valid <= 1'b0;
            key_idx    <= n_none;
            err        <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            if (mode_changed || ((mode_s2 != mode_play) && (mode_s2 != mode_review))) begin
                state    <= S_IDLE;
                cand     <= '0;
                deb_cnt  <= '0;
                rev_cnt  <= '0;
                note_out <= note_silence;
                key_idx  <= n_none;
                err      <= 1'b0;
            end else if (mode_s2 == mode_review) begin
                if (state != S_REVIEW) begin
                    state      <= S_REVIEW;
                    rev_cnt    <= '0;
                    key_idx    <= n_do;
                    note_out   <= map_tab[n_do];
                    note_valid <= 1'b1;
                    err        <= 1'b0;
                end else if (tick) begin
                    if (rev_cnt == (REV_LIM - 16'd1)) begin
                        rev_cnt    <= '0;
                        key_idx    <= rev_next;
                        note_out   <= map_tab[rev_next];
                        note_valid <= 1'b1;
                    end else begin
                        rev_cnt <= rev_cnt + 16'd1;
                    end
                end
            end else if (go_hold) begin
                state   <= S_HOLD;
                cand    <= key_s2;
                deb_cnt <= '0;
                if (key_entry != n_none) begin
                    key_idx    <= key_entry;
                    note_out   <= map_tab[key_entry];
                    note_valid <= 1'b1;
                    err        <= 1'b0;
                end else begin
                    key_idx  <= n_none;
                    note_out <= note_silence;
                    err      <= 1'b1;
                end
            end else if (go_release) begin
                // Only a real note going silent is a new output value; a
                // chord was already silent, so its release stays quiet.
                state      <= S_IDLE;
                cand       <= '0;
                deb_cnt    <= '0;
                note_out   <= note_silence;
                key_idx    <= n_none;
                err        <= 1'b0;
                note_valid <= (key_idx != n_none);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tick && (key_s2 != 7'd0)) begin
                            state   <= S_DEBOUNCE;
                            cand    <= key_s2;
                            deb_cnt <= 16'd1;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (tick) begin
                            if (key_s2 == cand) begin
                                deb_cnt <= deb_cnt + 16'd1;
                            end else if (key_s2 != 7'd0) begin
                                cand    <= key_s2;
                                deb_cnt <= 16'd1;
                            end else begin
                                state   <= S_IDLE;
                                cand    <= '0;
                                deb_cnt <= '0;
                            end
                        end
                    end
                    S_HOLD: begin
                        note_out <= map_tab[key_idx];
                        if (tick && (key_s2 != cand)) begin
                            state   <= S_RELEASE;
                            deb_cnt <= (key_s2 == 7'd0) ? 16'd1 : 16'd0;
                        end
                    end
                    S_RELEASE: begin
                        if (tick) begin
                            if (key_s2 == 7'd0) begin
                                deb_cnt <= deb_cnt + 16'd1;
                            end else begin
                                state   <= S_DEBOUNCE;
                                cand    <= key_s2;
                                deb_cnt <= 16'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        deb_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
